// File: rtl/ltssm_timer_sched.sv
// ltssm_timer_sched: round-robin sharing of one LTSSM interval timer among NUM_REQ requesters
module ltssm_timer_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                 i_pclk,
    input  logic                 i_reset_n,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [3*NUM_REQ-1:0] i_req_code,
    input  logic [NUM_REQ-1:0]   i_cancel,
    input  logic                 i_timer_timeout,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [NUM_REQ-1:0]   o_expired,
    output logic                 o_code_err,
    output logic                 o_busy,
    output logic                 o_timer_start,
    output logic                 o_timer_enable,
    output logic [2:0]           o_timer_interval_code
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [IDX_W-1:0] r_idx, r_last, w_win, w_c, w_next_idx;
    logic [2:0] w_win_code, r_code, w_code;
    logic w_bad, w_abort, w_new_grant;
    logic [NUM_REQ-1:0] r_grant, r_expired, w_grant, w_expired;
    logic r_code_err, r_busy, r_start, r_enable;
    always_comb begin
        w_win = r_last;
        w_c = r_last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_c = IDX_W'((int'(r_last) + k) % NUM_REQ);
            w_win = i_req[w_c] ? w_c : w_win;
        end
        w_win_code = 3'b000;
        for (int i = 0; i < NUM_REQ; i++)
            w_win_code = (w_win == IDX_W'(i)) ? i_req_code[3*i +: 3] : w_win_code;
        w_bad = &w_win_code[2:1];
        w_abort = i_cancel[r_idx] | ~i_req[r_idx];
    end
    always_ff @(posedge i_pclk) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_grant    <= '0;
            r_expired  <= '0;
            r_code_err <= 1'b0;
            r_busy     <= 1'b0;
            r_start    <= 1'b0;
            r_enable   <= 1'b0;
            r_code     <= 3'b000;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_next_idx;
            r_last     <= (r_state == LOAD) ? r_idx : r_last;
            r_grant    <= w_grant;
            r_expired  <= w_expired;
            r_code_err <= w_new_grant & w_bad;
            r_busy     <= w_next != IDLE;
            r_start    <= w_next == LOAD;
            r_enable   <= w_next == RUN;
            r_code     <= w_code;
        end
    end
    // abort (cancel or dropped request) outranks a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |i_req ? LOAD : IDLE;
            LOAD:    w_next = w_abort ? IDLE : RUN;
            RUN:     w_next = w_abort ? IDLE : (i_timer_timeout ? DONE : RUN);
            DONE:    w_next = i_req[r_idx] ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        w_new_grant = (r_state == IDLE) && (w_next == LOAD);
        w_next_idx = (r_state == IDLE) ? w_win : r_idx;
        w_grant = (w_next == IDLE) ? '0 : NUM_REQ'(1) << w_next_idx;
        w_expired = (r_state == RUN && w_next == DONE) ? NUM_REQ'(1) << r_idx : '0;
        w_code = w_new_grant ? (w_bad ? 3'b000 : w_win_code) : r_code;
    end
    assign o_grant = r_grant;
    assign o_expired = r_expired;
    assign o_code_err = r_code_err;
    assign o_busy = r_busy;
    assign o_timer_start = r_start;
    assign o_timer_enable = r_enable;
    assign o_timer_interval_code = r_code;
endmodule

// File: tb/tb_ltssm_timer_sched.sv
// tb_ltssm_timer_sched: directed checks of the timer scheduler against a behavioural interval timer
module tb_ltssm_timer_sched;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] req, cancel, grant, expired;
    logic [11:0] code;
    logic code_err, busy, t_start, t_en, tmo;
    logic [2:0] t_code;
    logic [7:0] tick = 8'd0;
    int ncmp = 0;
    int nfail = 0;

    ltssm_timer_sched #(.NUM_REQ(4), .IDX_W(2)) dut (
        .i_pclk(clk),
        .i_reset_n(rst_n),
        .i_req(req),
        .i_req_code(code),
        .i_cancel(cancel),
        .i_timer_timeout(tmo),
        .o_grant(grant),
        .o_expired(expired),
        .o_code_err(code_err),
        .o_busy(busy),
        .o_timer_start(t_start),
        .o_timer_enable(t_en),
        .o_timer_interval_code(t_code)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ival(input logic [2:0] c);
        case (c)
            3'b001:  return 8'd12;
            3'b010:  return 8'd24;
            3'b011:  return 8'd48;
            3'b100:  return 8'd2;
            3'b101:  return 8'd8;
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (t_start) tick <= 8'd0;
        else if (t_en) tick <= tick + 8'd1;
    end
    assign tmo = !t_start && (tick >= ival(t_code));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_expired"}, 32'(expired), 0);
        chk({tag, "_code_err"}, 32'(code_err), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_start"}, 32'(t_start), 0);
        chk({tag, "_enable"}, 32'(t_en), 0);
        chk({tag, "_tcode"}, 32'(t_code), 0);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; cancel = '0; code = '0;
        step(); step(); step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();
        // round-robin from a fresh reset: requester 0 first
        req = 4'hf;
        step();
        for (int g = 0; g < 5; g++) begin
            automatic int o = g % 4;
            chk("rr_grant", 32'(grant), 1 << o);
            chk("rr_start", 32'(t_start), 1);
            step();
            chk("rr_onehot", 32'($countones(grant) <= 1), 1);
            step();
            chk("rr_expired", 32'(expired), 1 << o);
            step();
            req[o] = 1'b0;
            step();
            chk("rr_idle", 32'(busy), 0);
            if (g < 4) begin
                step();
                req[o] = 1'b1;
            end else req = '0;
        end
        step();
        // single request, code 100 (2 ticks)
        code = 12'h004; req = 4'b0001;
        step();
        chk("single_grant", 32'(grant), 1);
        chk("single_start", 32'(t_start), 1);
        chk("single_en_load", 32'(t_en), 0);
        chk("single_busy", 32'(busy), 1);
        chk("single_tcode", 32'(t_code), 4);
        step();
        chk("single_en0", 32'(t_en), 1);
        chk("single_start_off", 32'(t_start), 0);
        code = 12'h003; cancel = 4'b0010;
        step();
        chk("single_code_held", 32'(t_code), 4);
        chk("single_en1", 32'(t_en), 1);
        cancel = '0;
        step();
        chk("single_no_early_exp", 32'(expired), 0);
        chk("single_en2", 32'(t_en), 1);
        step();
        chk("single_expired", 32'(expired), 1);
        chk("single_en_done", 32'(t_en), 0);
        chk("single_grant_done", 32'(grant), 1);
        step();
        chk("single_exp_pulse", 32'(expired), 0);
        chk("single_grant_held", 32'(grant), 1);
        step(); step(); step(); step();
        req = '0;
        step();
        chk("single_busy_off", 32'(busy), 0);
        chk("single_grant_off", 32'(grant), 0);
        // cancel in the 5th RUN cycle, owner 2 with code 001
        code = 12'h040; req = 4'b0100;
        step();
        chk("cancel_grant", 32'(grant), 4);
        step(); step(); step(); step(); step();
        cancel = 4'b0100;
        step();
        chk("cancel_grant_off", 32'(grant), 0);
        chk("cancel_en_off", 32'(t_en), 0);
        chk("cancel_no_exp", 32'(expired), 0);
        chk("cancel_busy_off", 32'(busy), 0);
        cancel = '0; req = 4'hf;
        step();
        chk("cancel_next_from3", 32'(grant), 8);
        chk("cancel_no_exp2", 32'(expired), 0);
        req = '0;
        step();
        chk("cancel_load_abort", 32'(busy), 0);
        // zero code
        code = 12'h000; req = 4'b0001;
        step();
        chk("zero_grant", 32'(grant), 1);
        step();
        chk("zero_no_exp_run", 32'(expired), 0);
        step();
        chk("zero_expired", 32'(expired), 1);
        req = '0;
        step();
        chk("zero_idle", 32'(busy), 0);
        // invalid code 111 on requester 1
        code = 12'h038; req = 4'b0010;
        step();
        chk("bad_code_err", 32'(code_err), 1);
        chk("bad_tcode", 32'(t_code), 0);
        chk("bad_grant", 32'(grant), 2);
        step();
        chk("bad_code_err_pulse", 32'(code_err), 0);
        step();
        chk("bad_expired", 32'(expired), 2);
        req = '0;
        step();
        chk("bad_idle", 32'(busy), 0);
        // cancel on the very cycle the timeout rises
        code = 12'h100; req = 4'b0100;
        step();
        chk("coll_grant", 32'(grant), 4);
        step(); step(); step();
        cancel = 4'b0100;
        step();
        chk("coll_no_exp", 32'(expired), 0);
        chk("coll_idle", 32'(busy), 0);
        chk("coll_grant_off", 32'(grant), 0);
        cancel = '0; req = '0;
        step();
        chk("coll_no_exp_late", 32'(expired), 0);
        // reset while running
        code = 12'h001; req = 4'b0001;
        step();
        chk("rst_run_grant", 32'(grant), 1);
        step(); step();
        chk("rst_run_en", 32'(t_en), 1);
        rst_n = 1'b0;
        step();
        chk_reset_vals("midrun");
        rst_n = 1'b1; req = 4'b1010;
        step();
        chk("post_reset_grant", 32'(grant), 2);
        chk("post_reset_start", 32'(t_start), 1);
        req = '0;
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
